// File: rtl/data_mem_access_unit.sv
// MEM-stage data memory access unit: req/ack handshake to a variable-latency memory,
// pipeline stall generation, misaligned-address and timeout detection.
module data_mem_access_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MEM_Flush,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_stall,
  output logic        misalign_err,
  output logic        timeout_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [29:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_d;
  logic             dm_req_d;
  logic             dm_we_d;
  logic [29:0]      dm_addr_d;
  logic [31:0]      dm_wdata_d;
  logic             misalign_d;
  logic             timeout_d;
  logic             start_c;
  logic             misaligned_c;

  // DONE blocks a new start so the completing instruction is not issued twice
  assign start_c      = (MemRead | MemWrite) & ~MEM_Flush & (state_q == IDLE);
  assign misaligned_c = (addr[1:0] != 2'b00);
  assign mem_stall    = start_c | (state_q == REQ);

  // Next-state and next-register values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata;
    dm_req_d   = dm_req;
    dm_we_d    = dm_we;
    dm_addr_d  = dm_addr;
    dm_wdata_d = dm_wdata;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          if (misaligned_c) begin
            misalign_d = 1'b1;
            rdata_d    = 32'd0;
            state_d    = DONE;
          end else begin
            dm_addr_d  = addr[31:2];
            dm_wdata_d = wdata;
            dm_we_d    = MemWrite;
            dm_req_d   = 1'b1;
            cnt_d      = '0;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        if (dm_ack) begin
          dm_req_d = 1'b0;
          if (!dm_we) rdata_d = dm_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          dm_req_d  = 1'b0;
          rdata_d   = 32'd0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rdata        <= 32'd0;
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= 30'd0;
      dm_wdata     <= 32'd0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdata        <= rdata_d;
      dm_req       <= dm_req_d;
      dm_we        <= dm_we_d;
      dm_addr      <= dm_addr_d;
      dm_wdata     <= dm_wdata_d;
      misalign_err <= misalign_d;
      timeout_err  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed, table-driven bench for data_mem_access_unit with hand sequences for
// timeout and reset-during-request.
module tb_data_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite, MEM_Flush;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        mem_stall, misalign_err, timeout_err;
  logic        dm_req, dm_we;
  logic [29:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemRead(MemRead), .MemWrite(MemWrite), .MEM_Flush(MEM_Flush),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .mem_stall(mem_stall), .misalign_err(misalign_err), .timeout_err(timeout_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  typedef struct {
    logic        rd, wr, fl;
    logic [31:0] a, wd;
    logic        ack;
    logic [31:0] rin;
    logic        x_stall, x_req, x_we;
    logic [29:0] x_addr;
    logic [31:0] x_wdata, x_rdata;
    logic        x_mis, x_to;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic rd, logic wr, logic fl, logic [31:0] a, logic [31:0] wd,
                              logic ack, logic [31:0] rin, logic x_stall, logic x_req,
                              logic x_we, logic [29:0] x_addr, logic [31:0] x_wdata,
                              logic [31:0] x_rdata, logic x_mis, logic x_to);
    vec_t v;
    v.rd = rd; v.wr = wr; v.fl = fl; v.a = a; v.wd = wd; v.ack = ack; v.rin = rin;
    v.x_stall = x_stall; v.x_req = x_req; v.x_we = x_we; v.x_addr = x_addr;
    v.x_wdata = x_wdata; v.x_rdata = x_rdata; v.x_mis = x_mis; v.x_to = x_to;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic fl, input logic [31:0] a,
                       input logic [31:0] wd, input logic ack, input logic [31:0] rin);
    MemRead = rd; MemWrite = wr; MEM_Flush = fl; addr = a; wdata = wd;
    dm_ack = ack; dm_rdata = rin;
  endtask

  initial begin
    int req_cnt;
    int to_cnt;
    logic [31:0] rdata_at_to;

    rst_n = 1'b0;
    drive(0, 0, 0, 32'd0, 32'd0, 0, 32'd0);

    // Table: stall checked before the edge, registered outputs after it
    vecs[0]  = mk(0,0,0,32'h00,32'h0,        0,32'h0,        0,0,0,30'h00,32'h0,        32'h0,        0,0);
    vecs[1]  = mk(1,0,0,32'h10,32'h0,        0,32'h0,        1,1,0,30'h04,32'h0,        32'h0,        0,0);
    vecs[2]  = mk(1,0,0,32'h10,32'h0,        0,32'h0,        1,1,0,30'h04,32'h0,        32'h0,        0,0);
    vecs[3]  = mk(1,0,0,32'h10,32'h0,        0,32'h0,        1,1,0,30'h04,32'h0,        32'h0,        0,0);
    vecs[4]  = mk(1,0,0,32'h10,32'h0,        1,32'hCAFEF00D, 1,0,0,30'h04,32'h0,        32'hCAFEF00D, 0,0);
    vecs[5]  = mk(1,0,0,32'h10,32'h0,        0,32'h0,        0,0,0,30'h04,32'h0,        32'hCAFEF00D, 0,0);
    vecs[6]  = mk(0,1,0,32'h20,32'h12345678, 0,32'h0,        1,1,1,30'h08,32'h12345678, 32'hCAFEF00D, 0,0);
    vecs[7]  = mk(0,1,0,32'h20,32'h12345678, 1,32'hDEADBEEF, 1,0,1,30'h08,32'h12345678, 32'hCAFEF00D, 0,0);
    vecs[8]  = mk(0,1,0,32'h20,32'h12345678, 0,32'h0,        0,0,1,30'h08,32'h12345678, 32'hCAFEF00D, 0,0);
    vecs[9]  = mk(1,0,0,32'h40,32'h0,        0,32'h0,        1,1,0,30'h10,32'h0,        32'hCAFEF00D, 0,0);
    vecs[10] = mk(1,0,1,32'h40,32'h0,        1,32'h0BADF00D, 1,0,0,30'h10,32'h0,        32'h0BADF00D, 0,0);
    vecs[11] = mk(1,0,0,32'h40,32'h0,        0,32'h0,        0,0,0,30'h10,32'h0,        32'h0BADF00D, 0,0);
    vecs[12] = mk(1,0,1,32'h50,32'h99,       0,32'h0,        0,0,0,30'h10,32'h0,        32'h0BADF00D, 0,0);
    vecs[13] = mk(0,0,0,32'h50,32'h0,        1,32'h77777777, 0,0,0,30'h10,32'h0,        32'h0BADF00D, 0,0);
    vecs[14] = mk(1,0,0,32'h13,32'h0,        0,32'h0,        1,0,0,30'h10,32'h0,        32'h0,        1,0);
    vecs[15] = mk(1,0,0,32'h13,32'h0,        0,32'h0,        0,0,0,30'h10,32'h0,        32'h0,        0,0);
    vecs[16] = mk(1,1,0,32'h60,32'hAAAA5555, 0,32'h0,        1,1,1,30'h18,32'hAAAA5555, 32'h0,        0,0);
    vecs[17] = mk(1,1,0,32'h60,32'hAAAA5555, 1,32'h11111111, 1,0,1,30'h18,32'hAAAA5555, 32'h0,        0,0);
    vecs[18] = mk(0,0,0,32'h00,32'h0,        0,32'h0,        0,0,1,30'h18,32'hAAAA5555, 32'h0,        0,0);

    step();
    step();
    chk("reset rdata", rdata, 32'd0);
    chk("reset dm_req", 32'(dm_req), 32'd0);
    chk("reset dm_addr", 32'(dm_addr), 32'd0);
    chk("reset mem_stall", 32'(mem_stall), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].fl, vecs[i].a, vecs[i].wd, vecs[i].ack, vecs[i].rin);
      #1;
      chk($sformatf("v%0d mem_stall", i), 32'(mem_stall), 32'(vecs[i].x_stall));
      step();
      chk($sformatf("v%0d dm_req", i), 32'(dm_req), 32'(vecs[i].x_req));
      chk($sformatf("v%0d dm_we", i), 32'(dm_we), 32'(vecs[i].x_we));
      chk($sformatf("v%0d dm_addr", i), 32'(dm_addr), 32'(vecs[i].x_addr));
      chk($sformatf("v%0d dm_wdata", i), dm_wdata, vecs[i].x_wdata);
      chk($sformatf("v%0d rdata", i), rdata, vecs[i].x_rdata);
      chk($sformatf("v%0d misalign_err", i), 32'(misalign_err), 32'(vecs[i].x_mis));
      chk($sformatf("v%0d timeout_err", i), 32'(timeout_err), 32'(vecs[i].x_to));
    end

    // Preload rdata with an immediate-ack load so the timeout clear is visible
    drive(1, 0, 0, 32'h80, 32'h0, 0, 32'h0);
    step();
    dm_ack = 1'b1; dm_rdata = 32'h13579BDF;
    step();
    drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    chk("preload rdata", rdata, 32'h13579BDF);
    step();

    // Timeout: ack never arrives
    req_cnt = 0;
    to_cnt = 0;
    rdata_at_to = 32'hFFFFFFFF;
    drive(1, 0, 0, 32'h100, 32'h0, 0, 32'h0);
    for (int c = 0; c < 40; c++) begin
      step();
      if (dm_req) req_cnt++;
      if (timeout_err) begin
        to_cnt++;
        rdata_at_to = rdata;
        MemRead = 1'b0;
      end
    end
    chk("timeout dm_req cycles", 32'(req_cnt), 32'd16);
    chk("timeout_err pulses", 32'(to_cnt), 32'd1);
    chk("timeout rdata", rdata_at_to, 32'd0);
    chk("timeout back idle stall", 32'(mem_stall), 32'd0);
    chk("timeout dm_addr", 32'(dm_addr), 32'h40);

    // Reset while waiting in REQ, then a late ack
    drive(1, 0, 0, 32'h200, 32'h0, 0, 32'h0);
    step();
    chk("rst-mid dm_req before", 32'(dm_req), 32'd1);
    rst_n = 1'b0;
    MemRead = 1'b0;
    step();
    chk("rst-mid dm_req", 32'(dm_req), 32'd0);
    chk("rst-mid mem_stall", 32'(mem_stall), 32'd0);
    chk("rst-mid dm_addr", 32'(dm_addr), 32'd0);
    rst_n = 1'b1;
    dm_ack = 1'b1; dm_rdata = 32'h5A5A5A5A;
    step();
    dm_ack = 1'b0;
    chk("late ack rdata", rdata, 32'd0);
    chk("late ack dm_req", 32'(dm_req), 32'd0);
    chk("late ack mem_stall", 32'(mem_stall), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
- Responder-side MEM-stage block. It consumes the MemRead/MemWrite/address/store-data produced by the Control decode path and carried through the ID/EX and EX/MEM pipeline registers.
- It performs the access against a variable-latency external data memory using a req/ack handshake.
- It holds the pipeline via mem_stall until the access completes, then returns load data for the write-back MemToReg mux.
- It also detects misaligned word addresses and memory timeouts.

Parameters:
- TIMEOUT, 16: number of REQ-state cycles without ack before the access is abandoned (minimum 2).
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- MemRead  input  1  load request from EX/MEM register
- MemWrite  input  1  store request from EX/MEM register
- MEM_Flush  input  1  suppresses starting a new access this cycle
- addr  input  32  byte address from ALU result
- wdata  input  32  store data (forwarded rt)
- rdata  output  32  load data to MEM/WB register
- mem_stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
- misalign_err  output  1  one-cycle pulse, addr[1:0]!=0 on access
- timeout_err  output  1  one-cycle pulse, ack not received within TIMEOUT
- dm_req  output  1  external request
- dm_we  output  1  external write enable
- dm_addr  output  30  word address (addr[31:2])
- dm_wdata  output  32  external store data
- dm_ack  input  1  external completion, single-cycle pulse
- dm_rdata  input  32  external read data, valid when dm_ack=1

Behaviour:
- Reset is synchronous and active-low on rst_n. On the clk edge with rst_n=0, every output and register clears:
  - state=IDLE; rdata=0; counter=0.
  - mem_stall, dm_req, dm_we, misalign_err and timeout_err = 0.
  - dm_addr=0; dm_wdata=0.
- Reset mid-transaction abandons the access; dm_req drops on that edge.
- Access start condition: start = (MemRead|MemWrite) & ~MEM_Flush & state==IDLE.
- MemWrite has priority if both MemRead and MemWrite are high; no error is raised.
- mem_stall is combinational: mem_stall = start | (state==REQ).
  - It is therefore high in the request cycle itself.
  - It is low in DONE, so the pipeline advances at the end of DONE.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If start and addr[1:0]!=0: no external access; pulse misalign_err next cycle; go DONE; rdata=0; mem_stall held only in the start cycle.
  - Else if start: latch addr[31:2]->dm_addr, wdata->dm_wdata, MemWrite->dm_we; set dm_req=1; counter=0; go REQ.
  - Otherwise stay in IDLE.
- REQ:
  - dm_req, dm_we, dm_addr and dm_wdata are held stable.
  - If dm_ack: dm_req=0; if not a write, rdata<=dm_rdata; go DONE.
  - Else if counter==TIMEOUT-1: dm_req=0; rdata<=0; timeout_err pulse in DONE; go DONE.
  - Else counter increments.
- DONE:
  - One cycle; go IDLE unconditionally.
  - A MemRead/MemWrite still high in this cycle belongs to the completing instruction and must not start a new access.
- rdata holds its last value until the next load completes; a store does not modify rdata.
- MEM_Flush is ignored once in REQ: the external access completes and the result is written to rdata normally, with no abort.
- Latency:
  - With ack arriving k cycles after dm_req rises (k>=1), the stall lasts k+1 cycles, then DONE.
  - Minimum stall is 2 cycles when ack arrives in the first REQ cycle.
- dm_ack outside REQ is ignored.

Test Plan:
- Aligned load: MemRead=1, addr=0x0000_0010, ack after 3 REQ cycles with dm_rdata=0xCAFE_F00D → dm_addr=0x4, dm_we=0, mem_stall high 4 cycles, rdata=0xCAFE_F00D in DONE, no err.
- Store: MemWrite=1, addr=0x20, wdata=0x1234_5678, immediate ack → dm_we=1, dm_wdata=0x1234_5678, stall 2 cycles, rdata unchanged.
- Misaligned: MemRead=1, addr=0x13 → dm_req never rises, misalign_err single pulse, rdata=0, stall 1 cycle.
- Timeout: load with dm_ack held 0, TIMEOUT=16 → dm_req high exactly 16 cycles, timeout_err pulse, rdata=0, FSM back to IDLE.
- Back-to-back plus flush: load then store in consecutive instructions → two distinct transactions, no double-start in DONE; request with MEM_Flush=1 → no dm_req; flush during REQ → access still completes.
- Reset mid-REQ: rst_n=0 during wait → next edge dm_req=0, mem_stall=0, state IDLE; late dm_ack ignored.
